// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirects, multicycle EX ops, blocking IO.
// All pipeline controls are combinational; only the EX-stall FSM and the stall counter are registered.
module pipeline_hazard_controller #(
    parameter logic [1:0] LOAD_SRC    = 2'd1,
    parameter int         STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4:0]             id_rs1_address,
    input  logic [4:0]             id_rs2_address,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             ex_rd_address,
    input  logic                   ex_reg_write_enable,
    input  logic [1:0]             ex_reg_write_data_src,
    input  logic                   ex_redirect,
    input  logic                   ex_mc_op,
    input  logic                   mc_done,
    input  logic                   ex_stdin_read_enable,
    input  logic                   stdin_valid,
    input  logic                   ex_stdout_write_enable,
    input  logic                   stdout_ready,
    output logic                   pc_write_enable,
    output logic                   if_id_write_enable,
    output logic                   if_id_flush,
    output logic                   id_ex_write_enable,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mc_start,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   ex_stall;
    logic                   load_use;
    logic                   rs1_hit, rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1_address == ex_rd_address);
    assign rs2_hit  = id_uses_rs2 && (id_rs2_address == ex_rd_address);
    assign load_use = ex_reg_write_enable && (ex_reg_write_data_src == LOAD_SRC) &&
                      (ex_rd_address != 5'd0) && (rs1_hit || rs2_hit);

    // A new multicycle op stalls on its issue cycle too: the result is not ready yet.
    assign ex_stall = ((state_q == RUN) && ex_mc_op) ||
                      ((state_q == MC_WAIT) && !mc_done) ||
                      (ex_stdin_read_enable && !stdin_valid) ||
                      (ex_stdout_write_enable && !stdout_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (ex_mc_op) state_d = MC_WAIT;
            MC_WAIT: if (mc_done)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ex_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

    always_comb begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        if_id_flush        = 1'b0;
        id_ex_write_enable = 1'b0;
        id_ex_flush        = 1'b0;
        ex_mem_flush       = 1'b0;
        mc_start           = 1'b0;
        if (reset_n) begin
            mc_start = (state_q == RUN) && ex_mc_op;
            if (ex_stall) begin
                ex_mem_flush = 1'b1;
            end else if (ex_redirect) begin
                // The ID instruction is squashed, so any load-use on it is moot.
                pc_write_enable    = 1'b1;
                if_id_write_enable = 1'b1;
                id_ex_write_enable = 1'b1;
                if_id_flush        = 1'b1;
                id_ex_flush        = 1'b1;
            end else if (load_use) begin
                id_ex_write_enable = 1'b1;
                id_ex_flush        = 1'b1;
            end else begin
                pc_write_enable    = 1'b1;
                if_id_write_enable = 1'b1;
                id_ex_write_enable = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboarded random + directed bench for pipeline_hazard_controller against a rule-level model.
module tb_pipeline_hazard_controller;

    localparam int W = 8;
    localparam int unsigned CMAX = (1 << W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] src;
        logic       redir, mc, done, sin_en, sin_v, sout_en, sout_r;
    } in_t;

    typedef struct {
        logic [6:0]   ctl;   // {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_fl, mc_start}
        int unsigned  cnt;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic id_uses_rs1, id_uses_rs2, ex_reg_write_enable;
    logic [1:0] ex_reg_write_data_src;
    logic ex_redirect, ex_mc_op, mc_done, ex_stdin_read_enable, stdin_valid;
    logic ex_stdout_write_enable, stdout_ready;
    logic pc_write_enable, if_id_write_enable, if_id_flush, id_ex_write_enable;
    logic id_ex_flush, ex_mem_flush, mc_start;
    logic [W-1:0] stall_cycles;

    pipeline_hazard_controller #(.LOAD_SRC(2'd1), .STALL_CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_reg_write_enable(ex_reg_write_enable),
        .ex_reg_write_data_src(ex_reg_write_data_src), .ex_redirect(ex_redirect),
        .ex_mc_op(ex_mc_op), .mc_done(mc_done),
        .ex_stdin_read_enable(ex_stdin_read_enable), .stdin_valid(stdin_valid),
        .ex_stdout_write_enable(ex_stdout_write_enable), .stdout_ready(stdout_ready),
        .pc_write_enable(pc_write_enable), .if_id_write_enable(if_id_write_enable),
        .if_id_flush(if_id_flush), .id_ex_write_enable(id_ex_write_enable),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mc_start(mc_start), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   drv_done = 1'b0;

    // Reference model state: is a multicycle op in flight, and how many stalled cycles so far.
    bit          m_busy = 1'b0;
    int unsigned m_cnt  = 0;

    function automatic in_t idle();
        in_t s = '0;
        s.rst_n = 1'b1; s.sin_v = 1'b1; s.sout_r = 1'b1;
        return s;
    endfunction

    task automatic drive(input in_t s, input string tag);
        exp_t e;
        bit stall, hazard, dep1, dep2;
        @(posedge clk); #1;
        reset_n = s.rst_n;
        id_rs1_address = s.rs1; id_rs2_address = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_rd_address = s.rd; ex_reg_write_enable = s.we; ex_reg_write_data_src = s.src;
        ex_redirect = s.redir; ex_mc_op = s.mc; mc_done = s.done;
        ex_stdin_read_enable = s.sin_en; stdin_valid = s.sin_v;
        ex_stdout_write_enable = s.sout_en; stdout_ready = s.sout_r;
        e.tag = tag;
        if (!s.rst_n) begin
            m_busy = 1'b0; m_cnt = 0;
            e.ctl = 7'b0; e.cnt = 0;
        end else begin
            // EX cannot finish if the mc result is pending or an IO handshake is not ready.
            stall = (s.mc && !m_busy) || (m_busy && !s.done) ||
                    (s.sin_en && !s.sin_v) || (s.sout_en && !s.sout_r);
            dep1 = s.u1 && s.rs1 == s.rd;
            dep2 = s.u2 && s.rs2 == s.rd;
            hazard = s.we && s.src == 2'd1 && s.rd != 0 && (dep1 || dep2);
            if (stall)        e.ctl = 7'b000_0010;
            else if (s.redir) e.ctl = 7'b111_1100;
            else if (hazard)  e.ctl = 7'b000_1100;
            else              e.ctl = 7'b110_1000;
            e.ctl[0] = s.mc && !m_busy;
            e.cnt = m_cnt;
            if (stall && m_cnt < CMAX) m_cnt++;
            if (!m_busy && s.mc) m_busy = 1'b1;
            else if (m_busy && s.done) m_busy = 1'b0;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e = sb.pop_front();
            act = {pc_write_enable, if_id_write_enable, if_id_flush, id_ex_write_enable,
                   id_ex_flush, ex_mem_flush, mc_start};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b expected %b", e.tag, act, e.ctl);
            end
            checks++;
            if (stall_cycles !== W'(e.cnt)) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", e.tag, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        in_t s;
        int  guard;
        s = idle(); s.rst_n = 1'b0;
        drive(s, "reset");
        drive(s, "reset_hold");

        // Load-use on rs1, then the bubble must not repeat once the load has moved on.
        s = idle(); s.we = 1; s.src = 2'd1; s.rd = 5; s.u1 = 1; s.rs1 = 5;
        drive(s, "load_use_rs1");
        s = idle(); s.u1 = 1; s.rs1 = 5;
        drive(s, "after_load_use");
        s = idle(); s.we = 1; s.src = 2'd1; s.rd = 0; s.u1 = 1; s.rs1 = 0;
        drive(s, "load_x0");
        s = idle(); s.we = 1; s.src = 2'd1; s.rd = 5; s.u2 = 0; s.rs2 = 5;
        drive(s, "load_rs2_unused");
        s = idle(); s.we = 1; s.src = 2'd1; s.rd = 7; s.u2 = 1; s.rs2 = 7;
        drive(s, "load_use_rs2");
        s = idle(); s.we = 1; s.src = 2'd0; s.rd = 7; s.u2 = 1; s.rs2 = 7;
        drive(s, "alu_no_stall");

        // Multicycle: issue cycle + 4 waiting cycles, release on mc_done, plus a stray done in RUN.
        s = idle(); s.mc = 1;
        for (int i = 0; i < 5; i++) drive(s, "mc_wait");
        s.done = 1;
        drive(s, "mc_release");
        s = idle(); s.done = 1;
        drive(s, "mc_done_in_run");

        // Stdin blocked 3 cycles with a redirect pending; redirect acts on the release cycle.
        s = idle(); s.sin_en = 1; s.sin_v = 0; s.redir = 1;
        for (int i = 0; i < 3; i++) drive(s, "stdin_block");
        s.sin_v = 1;
        drive(s, "stdin_release_redir");
        s = idle(); s.sout_en = 1; s.sout_r = 0;
        drive(s, "stdout_block");

        s = idle(); s.redir = 1; s.we = 1; s.src = 2'd1; s.rd = 3; s.u1 = 1; s.rs1 = 3;
        drive(s, "redir_and_load_use");

        // IO blocking while a multicycle op issues still starts the unit.
        s = idle(); s.mc = 1; s.sout_en = 1; s.sout_r = 0;
        drive(s, "mc_issue_io_block");
        s.done = 1;
        drive(s, "mc_done_io_block");
        s.sout_r = 1;
        drive(s, "mc_after_done");
        s = idle();
        drive(s, "idle");

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.we = 1'($urandom);
            s.src = 2'($urandom);
            s.redir = ($urandom_range(0, 3) == 0);
            s.mc = ($urandom_range(0, 5) == 0) || m_busy;
            s.done = m_busy && ($urandom_range(0, 3) == 0);
            s.sin_en = ($urandom_range(0, 4) == 0); s.sin_v = 1'($urandom);
            s.sout_en = ($urandom_range(0, 4) == 0); s.sout_r = 1'($urandom);
            drive(s, "random");
        end

        // Drive the counter into saturation, then check it holds at max.
        s = idle(); s.sin_en = 1; s.sin_v = 0;
        for (int i = 0; i < 300; i++) drive(s, "saturate");
        s = idle();
        drive(s, "sat_hold");

        // Reset in the middle of a multicycle wait.
        s = idle(); s.mc = 1;
        for (int i = 0; i < 3; i++) drive(s, "mc_pre_reset");
        s.rst_n = 1'b0;
        drive(s, "reset_mid_mc");
        s = idle();
        drive(s, "after_reset");
        drive(s, "after_reset2");

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        drv_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        if (!drv_done) begin
            $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
            $fatal(1, "timeout");
        end
    end

endmodule
